// File: rtl/spi_cmd_receiver.sv
// Serial command front end of the FM25Q08A flash model: frames opcode/address/data on CLK rising edges.
// Optional SPI mode 3 start qualification is enabled with `define SPI_RX_MODE3_EN (adds CPOL input).
module spi_cmd_receiver #(
  parameter int ADDR_W     = 24,
  parameter int PAGE_BYTES = 256,
  parameter int FAST_DUMMY = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              S_N,
  input  logic              DI,
`ifdef SPI_RX_MODE3_EN
  input  logic              CPOL,
`endif
  output logic [7:0]        instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic [7:0]        data,
  output logic              data_valid,
  output logic [8:0]        data_cnt,
  output logic              frame_done,
  output logic              frame_ok,
  output logic              bad_opcode,
  output logic [2:0]        state_dbg
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_OPC   = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_DUMMY = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_IGN   = 3'd6;

  localparam int          SR_W       = (ADDR_W > 8) ? ADDR_W : 8;
  localparam logic [5:0]  ADDR_LAST  = 6'(ADDR_W - 1);
  localparam logic [5:0]  DUMMY_LAST = 6'(FAST_DUMMY - 1);
  localparam logic [8:0]  PAGE_MAX   = 9'(PAGE_BYTES);
  localparam bit          HAS_DUMMY  = (FAST_DUMMY > 0);

  // Handshake: every *_valid and frame_done is a single-cycle pulse, no back-pressure;
  // the paired data output is stable on the cycle the pulse is high. frame_ok is only
  // meaningful while frame_done is high.

  logic [2:0]      state;
  logic [5:0]      bit_cnt;
  logic [SR_W-2:0] sr;
  logic [SR_W-1:0] next_sr;
  logic            overflow;
  logic            extra;
  logic            end_ok;
  logic            start_ok;

  assign next_sr   = {sr, DI};
  assign state_dbg = state;

`ifdef SPI_RX_MODE3_EN
  // In mode 3 the frame may only begin once CLK has fallen with the chip selected,
  // so a rising edge left over from the idle-high clock is not taken as bit 7.
  logic sel_at_fall;
  always_ff @(negedge CLK or negedge RST_N) begin
    if (!RST_N) sel_at_fall <= 1'b0;
    else        sel_at_fall <= ~S_N;
  end
  assign start_ok = ~CPOL | sel_at_fall;
`else
  assign start_ok = 1'b1;
`endif

  function automatic logic [2:0] after_opcode(input logic [7:0] op);
    case (op)
      8'h02, 8'h03, 8'h0B, 8'h20, 8'hD8: return S_ADDR;
      8'h06, 8'h04, 8'h05, 8'hC7:        return S_DONE;
      default:                           return S_IGN;
    endcase
  endfunction

  // Integrity at frame end: only DATA (on a byte boundary) and a clean DONE wait are good.
  always_comb begin
    end_ok = 1'b0;
    case (state)
      S_DATA:  end_ok = (bit_cnt == 6'd0) && !overflow;
      S_DONE:  end_ok = !extra;
      default: end_ok = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= S_IDLE;
      bit_cnt     <= '0;
      sr          <= '0;
      overflow    <= 1'b0;
      extra       <= 1'b0;
      instr       <= '0;
      instr_valid <= 1'b0;
      addr        <= '0;
      addr_valid  <= 1'b0;
      data        <= '0;
      data_valid  <= 1'b0;
      data_cnt    <= '0;
      frame_done  <= 1'b0;
      frame_ok    <= 1'b0;
      bad_opcode  <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      addr_valid  <= 1'b0;
      data_valid  <= 1'b0;
      frame_done  <= 1'b0;
      frame_ok    <= 1'b0;
      if (S_N) begin
        if (state != S_IDLE) begin
          frame_done <= 1'b1;
          frame_ok   <= end_ok;
        end
        state   <= S_IDLE;
        bit_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_ok) begin
              state      <= S_OPC;
              sr         <= next_sr[SR_W-2:0];
              bit_cnt    <= 6'd1;
              bad_opcode <= 1'b0;
              data_cnt   <= '0;
              overflow   <= 1'b0;
              extra      <= 1'b0;
            end
          end
          S_OPC: begin
            sr <= next_sr[SR_W-2:0];
            if (bit_cnt == 6'd7) begin
              instr       <= next_sr[7:0];
              instr_valid <= 1'b1;
              bit_cnt     <= '0;
              state       <= after_opcode(next_sr[7:0]);
              if (after_opcode(next_sr[7:0]) == S_IGN) bad_opcode <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
          S_ADDR: begin
            sr <= next_sr[SR_W-2:0];
            if (bit_cnt == ADDR_LAST) begin
              addr       <= next_sr[ADDR_W-1:0];
              addr_valid <= 1'b1;
              bit_cnt    <= '0;
              if (instr == 8'h02)                   state <= S_DATA;
              else if (instr == 8'h0B && HAS_DUMMY) state <= S_DUMMY;
              else                                  state <= S_DONE;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
          S_DUMMY: begin
            if (bit_cnt == DUMMY_LAST) begin
              bit_cnt <= '0;
              state   <= S_DONE;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
          S_DATA: begin
            sr <= next_sr[SR_W-2:0];
            if (bit_cnt == 6'd7) begin
              bit_cnt <= '0;
              // Bytes past the page are dropped; the count holds at the page size.
              if (data_cnt != PAGE_MAX) begin
                data       <= next_sr[7:0];
                data_valid <= 1'b1;
                data_cnt   <= data_cnt + 9'd1;
              end else begin
                overflow <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
          S_DONE, S_IGN: begin
            extra <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_receiver.sv
// Scoreboard bench for spi_cmd_receiver: frames are modelled as bit lists, expectations queued, a monitor pops them.
module tb_spi_cmd_receiver;
  localparam int AW = 24;
  localparam int PB = 256;
  localparam int FD = 8;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          S_N;
  logic          DI;
  logic [7:0]    instr;
  logic          instr_valid;
  logic [AW-1:0] addr;
  logic          addr_valid;
  logic [7:0]    data;
  logic          data_valid;
  logic [8:0]    data_cnt;
  logic          frame_done;
  logic          frame_ok;
  logic          bad_opcode;
  logic [2:0]    state_dbg;
`ifdef SPI_RX_MODE3_EN
  logic          CPOL = 1'b0;
`endif

  spi_cmd_receiver #(.ADDR_W(AW), .PAGE_BYTES(PB), .FAST_DUMMY(FD)) dut (
    .CLK(CLK), .RST_N(RST_N), .S_N(S_N), .DI(DI),
`ifdef SPI_RX_MODE3_EN
    .CPOL(CPOL),
`endif
    .instr(instr), .instr_valid(instr_valid), .addr(addr), .addr_valid(addr_valid),
    .data(data), .data_valid(data_valid), .data_cnt(data_cnt), .frame_done(frame_done),
    .frame_ok(frame_ok), .bad_opcode(bad_opcode), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int tests_run = 0;
  int fails     = 0;

  logic [7:0]    exp_instr_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [7:0]    exp_data_q[$];
  logic [10:0]   exp_frame_q[$];   // {frame_ok, bad_opcode, data_cnt}
  bit            fq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    tests_run++;
    fails++;
    $display("FAIL %s: pulse seen with nothing expected", name);
  endtask

  // reference model: a frame is judged purely by its bit list length and content
  task automatic model_frame();
    int len;
    int rem;
    int nb;
    int acc;
    logic [7:0] op;
    logic [AW-1:0] a;
    logic [7:0] b;
    len = fq.size();
    if (len < 8) begin
      exp_frame_q.push_back({1'b0, 1'b0, 9'd0});
      return;
    end
    op = '0;
    for (int i = 0; i < 8; i++) op = {op[6:0], fq[i]};
    exp_instr_q.push_back(op);
    if (op inside {8'h06, 8'h04, 8'h05, 8'hC7}) begin
      exp_frame_q.push_back({len == 8, 1'b0, 9'd0});
      return;
    end
    if (!(op inside {8'h02, 8'h03, 8'h0B, 8'h20, 8'hD8})) begin
      exp_frame_q.push_back({1'b0, 1'b1, 9'd0});
      return;
    end
    if (len < 8 + AW) begin
      exp_frame_q.push_back({1'b0, 1'b0, 9'd0});
      return;
    end
    a = '0;
    for (int i = 8; i < 8 + AW; i++) a = {a[AW-2:0], fq[i]};
    exp_addr_q.push_back(a);
    rem = len - 8 - AW;
    if (op == 8'h02) begin
      nb  = rem / 8;
      acc = (nb > PB) ? PB : nb;
      for (int k = 0; k < acc; k++) begin
        b = '0;
        for (int j = 0; j < 8; j++) b = {b[6:0], fq[8 + AW + 8*k + j]};
        exp_data_q.push_back(b);
      end
      exp_frame_q.push_back({(rem % 8 == 0) && (nb <= PB), 1'b0, 9'(acc)});
    end else if (op == 8'h0B) begin
      exp_frame_q.push_back({rem == FD, 1'b0, 9'd0});
    end else begin
      exp_frame_q.push_back({rem == 0, 1'b0, 9'd0});
    end
  endtask

  // driver tasks
  task automatic add_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) fq.push_back(v[i]);
  endtask

  task automatic run_frame();
    model_frame();
    foreach (fq[i]) begin
      @(negedge CLK);
      S_N = 1'b0;
      DI  = fq[i];
    end
    @(negedge CLK);
    S_N = 1'b1;
    DI  = 1'($urandom_range(0, 1));
    fq.delete();
  endtask

  // monitor / scoreboard
  always @(negedge CLK) begin
    if (RST_N === 1'b1) begin
      if (instr_valid) begin
        if (exp_instr_q.size() == 0) unexpected("instr_valid");
        else check("instr", 32'(instr), 32'(exp_instr_q.pop_front()));
      end
      if (addr_valid) begin
        if (exp_addr_q.size() == 0) unexpected("addr_valid");
        else check("addr", 32'(addr), 32'(exp_addr_q.pop_front()));
      end
      if (data_valid) begin
        if (exp_data_q.size() == 0) unexpected("data_valid");
        else check("data", 32'(data), 32'(exp_data_q.pop_front()));
      end
      if (frame_done) begin
        check("pulse_overlap", {29'd0, instr_valid, addr_valid, data_valid}, 32'd0);
        if (exp_frame_q.size() == 0) unexpected("frame_done");
        else begin
          logic [10:0] e;
          e = exp_frame_q.pop_front();
          check("frame_ok", 32'(frame_ok), 32'(e[10]));
          check("bad_opcode", 32'(bad_opcode), 32'(e[9]));
          check("data_cnt", 32'(data_cnt), 32'(e[8:0]));
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_instr"}, 32'(instr), 32'd0);
    check({tag, "_addr"}, 32'(addr), 32'd0);
    check({tag, "_data"}, 32'(data), 32'd0);
    check({tag, "_data_cnt"}, 32'(data_cnt), 32'd0);
    check({tag, "_pulses"}, {28'd0, instr_valid, addr_valid, data_valid, frame_done}, 32'd0);
    check({tag, "_flags"}, {30'd0, frame_ok, bad_opcode}, 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'd0);
  endtask

  logic [7:0] ops [11] = '{8'h02, 8'h03, 8'h0B, 8'h20, 8'hD8, 8'h06, 8'h04, 8'h05, 8'hC7, 8'h9F, 8'h00};

  initial begin
    logic [7:0] op;
    int idx;
    int mode;
    int n;
    RST_N = 1'b0;
    S_N   = 1'b1;
    DI    = 1'b0;
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    RST_N = 1'b1;
    @(negedge CLK);

    // directed frames
    add_bits(32'h06, 8); run_frame();
    add_bits(32'h03, 8); add_bits(32'h012345, AW); run_frame();
    add_bits(32'h02, 8); add_bits(32'h000100, AW);
    add_bits(32'hA5, 8); add_bits(32'h5A, 8); add_bits(32'hFF, 8); run_frame();
    add_bits(32'h02, 8); add_bits(32'h000000, AW);
    for (int i = 0; i < 257; i++) add_bits($urandom_range(0, 255), 8);
    run_frame();
    add_bits(32'h0B, 8); add_bits(32'h0000FF, AW); add_bits($urandom, FD); run_frame();
    add_bits(32'h0B, 8); add_bits(32'h0000FF, AW); add_bits($urandom, 5); run_frame();
    add_bits(32'h9F, 8); run_frame();
    add_bits(32'h06, 8); add_bits(32'h0, 3); run_frame();
    add_bits(32'hD8, 8); add_bits(32'h0ABCDE, 12); run_frame();

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      idx = $urandom_range(0, 11);
      op  = (idx == 11) ? 8'($urandom_range(0, 255)) : ops[idx];
      add_bits(32'(op), 8);
      if (op inside {8'h02, 8'h03, 8'h0B, 8'h20, 8'hD8}) add_bits($urandom, AW);
      if (op == 8'h02) begin
        n = $urandom_range(0, 5);
        for (int k = 0; k < n; k++) add_bits($urandom_range(0, 255), 8);
      end
      if (op == 8'h0B) add_bits($urandom, FD);
      mode = $urandom_range(0, 3);
      if (mode == 1) begin
        n = $urandom_range(1, (fq.size() > 10) ? 10 : fq.size() - 1);
        repeat (n) void'(fq.pop_back());
      end else if (mode == 2) begin
        add_bits($urandom, $urandom_range(1, 9));
      end
      run_frame();
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

    // reset in the middle of a read frame
    exp_instr_q.push_back(8'h03);
    add_bits(32'h03, 8); add_bits(32'h012345, AW);
    for (int i = 0; i < 13; i++) begin
      @(negedge CLK);
      S_N = 1'b0;
      DI  = fq[i];
    end
    fq.delete();
    @(negedge CLK);
    #2 RST_N = 1'b0;
    S_N = 1'b1;
    #1 check_all_zero("midreset");
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    add_bits(32'h06, 8); run_frame();

    // drain with a bounded wait
    for (int i = 0; i < 20; i++) begin
      if (exp_instr_q.size() + exp_addr_q.size() + exp_data_q.size() + exp_frame_q.size() == 0) break;
      @(negedge CLK);
    end
    check("left_instr", 32'(exp_instr_q.size()), 32'd0);
    check("left_addr", 32'(exp_addr_q.size()), 32'd0);
    check("left_data", 32'(exp_data_q.size()), 32'd0);
    check("left_frame", 32'(exp_frame_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $fatal(1, "time limit");
  end

endmodule
